rr_bus_arbiter_n: RTL and testbench

Parametrised N-way round-robin bus arbiter with a per-grant hold quantum. It is the next generation of the team's 4-requester arbiter. The block sits between N bus masters and the shared bus mux. It adds three things over the earlier arbiter: an arbitrary requester count, a grant that is held for up to MAX_HOLD cycles while the owner keeps requesting, and binary grant-index and valid outputs for driving the mux select directly.

---
 rtl/rr_bus_arbiter_n.sv | 120 ++++++++++++
 tb/tb_rr_bus_arbiter_n.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter_n.sv
// N-way round-robin bus arbiter with a per-grant hold quantum.
// Drives a registered one-hot grant plus binary grant_id/grant_valid for the bus mux select.
module rr_bus_arbiter_n #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 req,
    output logic [N-1:0]                 grant,
    output logic                         grant_valid,
    output logic [$clog2(N)-1:0]         grant_id
);

    localparam int unsigned IDW = $clog2(N);
    localparam int unsigned CW  = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWNED = 2'b01
    } state_t;

    state_t         state, next_state;
    logic [IDW-1:0] owner, next_owner;
    logic [CW-1:0]  hold_cnt, next_cnt;

    logic [N-1:0]   owner_hot;
    logic           owner_req;
    logic           owner_bad;
    logic           found_all, found_other;
    logic [IDW-1:0] win_all, win_other;

    assign owner_hot = N'(1) << owner;
    assign owner_req = |(req & owner_hot);
    assign owner_bad = 32'(owner) >= N;

    // Rotating search from owner+1 upward; owner itself is visited last.
    always_comb begin
        int unsigned idx;
        found_all   = 1'b0;
        found_other = 1'b0;
        win_all     = owner;
        win_other   = owner;
        idx         = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(owner) + i) % N;
            if (!found_all && req[idx]) begin
                found_all = 1'b1;
                win_all   = IDW'(idx);
            end
            if (!found_other && req[idx] && (idx != 32'(owner))) begin
                found_other = 1'b1;
                win_other   = IDW'(idx);
            end
        end
    end

    // Next-state and next-owner decision.
    always_comb begin
        next_state = state;
        next_owner = owner;
        next_cnt   = hold_cnt;
        if (owner_bad) begin
            next_state = IDLE;
            next_owner = IDW'(N - 1);
            next_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found_all) begin
                        next_state = OWNED;
                        next_owner = win_all;
                        next_cnt   = CW'(1);
                    end
                end
                OWNED: begin
                    if (!owner_req) begin
                        if (found_other) begin
                            next_owner = win_other;
                            next_cnt   = CW'(1);
                        end else begin
                            next_state = IDLE;
                            next_cnt   = '0;
                        end
                    end else if (hold_cnt < CW'(MAX_HOLD)) begin
                        next_cnt = hold_cnt + CW'(1);
                    end else if (found_other) begin
                        next_owner = win_other;
                        next_cnt   = CW'(1);
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_owner = IDW'(N - 1);
                    next_cnt   = '0;
                end
            endcase
        end
    end

    // State and outputs registered together so grant always matches owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= IDW'(N - 1);
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= IDW'(N - 1);
        end else begin
            state       <= next_state;
            owner       <= next_owner;
            hold_cnt    <= next_cnt;
            grant       <= (next_state == OWNED) ? (N'(1) << next_owner) : '0;
            grant_valid <= (next_state == OWNED);
            grant_id    <= next_owner;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter_n.sv
// Bench for rr_bus_arbiter_n (N=4, MAX_HOLD=3): vector table, corner sequences,
// and random traffic against a round-robin reference model.
module tb_rr_bus_arbiter_n;

    localparam int unsigned N  = 4;
    localparam int unsigned MH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
    } vec_t;

    vec_t tbl[$];

    int m_owner;
    int m_held;
    bit m_busy;

    rr_bus_arbiter_n #(.N(N), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] g, input logic v, input logic [1:0] id);
        tests++;
        if (grant !== g || grant_valid !== v || grant_id !== id) begin
            fails++;
            $display("FAIL %s: got grant=%b valid=%b id=%0d, expected grant=%b valid=%b id=%0d",
                     name, grant, grant_valid, grant_id, g, v, id);
        end
    endtask

    function automatic void add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id);
        vec_t e;
        e.req = r; e.g = g; e.v = (g != 4'b0000); e.id = id;
        tbl.push_back(e);
    endfunction

    task automatic do_reset(input logic [3:0] r);
        @(negedge clk);
        rst = 1'b0;
        req = r;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_owner = N - 1; m_held = 0; m_busy = 0;
    endtask

    // First requester met walking upward from owner+1 (mod N).
    function automatic int pick(input logic [3:0] r, input bit exclude_owner);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_owner + k) % N;
            if (exclude_owner && c == m_owner) continue;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        int w;
        if (!m_busy) begin
            w = pick(r, 0);
            if (w >= 0) begin m_busy = 1; m_owner = w; m_held = 1; end
        end else if (!r[m_owner]) begin
            w = pick(r, 1);
            if (w >= 0) begin m_owner = w; m_held = 1; end
            else m_busy = 0;
        end else if (m_held < MH) begin
            m_held++;
        end else begin
            w = pick(r, 1);
            if (w >= 0) begin m_owner = w; m_held = 1; end
        end
    endfunction

    initial begin
        logic [3:0] exp_g;
        logic [3:0] r;

        // Reset held with everyone requesting
        rst = 1'b0;
        req = 4'b1111;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_hold", 4'b0000, 1'b0, 2'd3);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("reset_first_edge", 4'b0001, 1'b1, 2'd0);

        // Table: full contention, pointer persistence, early release
        for (int i = 0; i < 3; i++) add(4'b1111, 4'b0001, 2'd0);
        for (int i = 0; i < 3; i++) add(4'b1111, 4'b0010, 2'd1);
        for (int i = 0; i < 3; i++) add(4'b1111, 4'b0100, 2'd2);
        for (int i = 0; i < 3; i++) add(4'b1111, 4'b1000, 2'd3);
        for (int i = 0; i < 3; i++) add(4'b1111, 4'b0001, 2'd0);
        add(4'b0000, 4'b0000, 2'd0);
        add(4'b0101, 4'b0100, 2'd2);
        add(4'b0000, 4'b0000, 2'd2);
        add(4'b0000, 4'b0000, 2'd2);
        add(4'b0101, 4'b0001, 2'd0);
        add(4'b0011, 4'b0001, 2'd0);
        add(4'b0010, 4'b0010, 2'd1);
        add(4'b0011, 4'b0010, 2'd1);
        add(4'b0011, 4'b0010, 2'd1);
        add(4'b0011, 4'b0001, 2'd0);

        do_reset(4'b0000);
        foreach (tbl[i]) begin
            @(negedge clk); req = tbl[i].req;
            @(posedge clk); #1;
            check($sformatf("table[%0d]", i), tbl[i].g, tbl[i].v, tbl[i].id);
        end

        // Single requester saturates, then releases to idle
        do_reset(4'b0000);
        @(negedge clk); req = 4'b0100;
        repeat (10) begin
            @(posedge clk); #1;
            check("single_hold", 4'b0100, 1'b1, 2'd2);
        end
        @(negedge clk); req = 4'b0000;
        @(posedge clk); #1;
        check("single_release", 4'b0000, 1'b0, 2'd2);

        // Early release from a fresh grant: no idle gap
        do_reset(4'b0000);
        @(negedge clk); req = 4'b0011;
        @(posedge clk); #1;
        check("early_first", 4'b0001, 1'b1, 2'd0);
        @(negedge clk); req = 4'b0010;
        @(posedge clk); #1;
        check("early_handoff", 4'b0010, 1'b1, 2'd1);

        // Asynchronous reset mid-grant
        do_reset(4'b0000);
        @(negedge clk); req = 4'b1111;
        repeat (7) @(posedge clk);
        #1 check("pre_async", 4'b0100, 1'b1, 2'd2);
        #2 rst = 1'b0;
        #1 check("async_reset", 4'b0000, 1'b0, 2'd3);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("after_async", 4'b0001, 1'b1, 2'd0);

        // Random traffic against the reference model
        do_reset(4'b0000);
        r = 4'b0000;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 9) < 6);
            end
            req = r;
            @(posedge clk); #1;
            model_step(r);
            exp_g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            check($sformatf("random[%0d]", cyc), exp_g, m_busy, 2'(m_owner));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
